// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and byte-lane helper for the systolic feeder.
package systolic_pkg;

    localparam int PE_DIM       = 4;
    localparam int LANE_W       = 8;
    localparam int ACC_W        = 32;
    localparam int DRAIN_CYCLES = 9;
    localparam int FEED_TO_DONE = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Extract byte lane 'lane' from a packed operand word (lane 0 in the LSBs).
    function automatic logic [LANE_W-1:0] lane_byte(
        input logic [PE_DIM*LANE_W-1:0] word,
        input int                       lane
    );
        return word[lane*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth byte shift register used to skew one array input stream.
module skew_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [DEPTH-1:0][7:0] stage_q;
    logic [DEPTH-1:0][7:0] stage_d;

    // Each stage takes the previous one; stage 0 takes the new byte.
    always_comb begin
        stage_d[0] = din;
        for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    // Shift every cycle; reset empties the line so the array sees zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 int8 output-stationary PE array: sequences
// buffer reads, skews the byte streams and frames each tile with clear/done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int KLEN_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KLEN_W-1:0] k_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              busy,
    output logic              done,
    output logic              a_en,
    output logic              b_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       a_rdata,
    input  logic [31:0]       b_rdata,
    output logic              pe_clear,
    output logic [7:0]        pe_a0,
    output logic [7:0]        pe_a1,
    output logic [7:0]        pe_a2,
    output logic [7:0]        pe_a3,
    output logic [7:0]        pe_b0,
    output logic [7:0]        pe_b1,
    output logic [7:0]        pe_b2,
    output logic [7:0]        pe_b3
);

    state_t            state_q,    state_d;
    logic [KLEN_W-1:0] cnt_q,      cnt_d;
    logic [KLEN_W-1:0] k_len_q,    k_len_d;
    logic [ADDR_W-1:0] a_base_q,   a_base_d;
    logic [ADDR_W-1:0] b_base_q,   b_base_d;
    logic [ADDR_W-1:0] a_addr_q,   a_addr_d;
    logic [ADDR_W-1:0] b_addr_q,   b_addr_d;
    logic              rd_en_q,    rd_en_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              clear_q,    clear_d;

    logic [LANE_W-1:0] a_lane_in  [PE_DIM];
    logic [LANE_W-1:0] b_lane_in  [PE_DIM];
    logic [LANE_W-1:0] a_lane_out [PE_DIM];
    logic [LANE_W-1:0] b_lane_out [PE_DIM];

    // Next-state, counters and the registered versions of every control output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_len_d    = k_len_q;
        a_base_d   = a_base_q;
        b_base_d   = b_base_q;
        a_addr_d   = '0;
        b_addr_d   = '0;
        rd_en_d    = 1'b0;
        rd_valid_d = rd_en_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    k_len_d  = k_len;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    cnt_d    = '0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = '0;
                if (k_len_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    state_d  = FEED;
                    rd_en_d  = 1'b1;
                    a_addr_d = a_base_q;
                    b_addr_d = b_base_q;
                end
            end
            FEED: begin
                if (cnt_q == k_len_q - KLEN_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d    = cnt_q + KLEN_W'(1);
                    rd_en_d  = 1'b1;
                    a_addr_d = a_addr_q + ADDR_W'(1);
                    b_addr_d = b_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == KLEN_W'(DRAIN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + KLEN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        clear_d = (state_d == CLEAR);
    end

    // Single sequencer register bank; outputs are flops so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_len_q    <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_len_q    <= k_len_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
            rd_en_q    <= rd_en_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clear_q    <= clear_d;
        end
    end

    // Buffer data is only meaningful the cycle after a read; otherwise feed zeros.
    always_comb begin
        for (int i = 0; i < PE_DIM; i++) begin
            a_lane_in[i] = rd_valid_q ? lane_byte(a_rdata, i) : '0;
            b_lane_in[i] = rd_valid_q ? lane_byte(b_rdata, i) : '0;
        end
    end

    for (genvar g = 0; g < PE_DIM; g++) begin : g_lane
        skew_delay_line #(.DEPTH(g + 1)) u_a_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (a_lane_in[g]),
            .dout (a_lane_out[g])
        );
        skew_delay_line #(.DEPTH(g + 1)) u_b_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (b_lane_in[g]),
            .dout (b_lane_out[g])
        );
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign a_en     = rd_en_q;
    assign b_en     = rd_en_q;
    assign a_addr   = a_addr_q;
    assign b_addr   = b_addr_q;
    assign pe_clear = clear_q;
    assign pe_a0    = a_lane_out[0];
    assign pe_a1    = a_lane_out[1];
    assign pe_a2    = a_lane_out[2];
    assign pe_a3    = a_lane_out[3];
    assign pe_b0    = b_lane_out[0];
    assign pe_b1    = b_lane_out[1];
    assign pe_b2    = b_lane_out[2];
    assign pe_b3    = b_lane_out[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-cycle expected output frames plus
// a behavioural PE array whose accumulators are checked at every done pulse.
module tb_systolic_feeder;

    localparam int ADDR_W = 10;
    localparam int KLEN_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KLEN_W-1:0] k_len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic              busy, done, a_en, b_en, pe_clear;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [31:0]       a_rdata, b_rdata;
    logic [7:0]        pe_a0, pe_a1, pe_a2, pe_a3;
    logic [7:0]        pe_b0, pe_b1, pe_b2, pe_b3;

    always #5 clk = ~clk;

    systolic_feeder #(.ADDR_W(ADDR_W), .KLEN_W(KLEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_base(a_base), .b_base(b_base), .busy(busy), .done(done),
        .a_en(a_en), .b_en(b_en), .a_addr(a_addr), .b_addr(b_addr),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .pe_clear(pe_clear),
        .pe_a0(pe_a0), .pe_a1(pe_a1), .pe_a2(pe_a2), .pe_a3(pe_a3),
        .pe_b0(pe_b0), .pe_b1(pe_b1), .pe_b2(pe_b2), .pe_b3(pe_b3)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pe_clear;
        logic        a_en;
        logic        b_en;
        logic [9:0]  a_addr;
        logic [9:0]  b_addr;
        logic [31:0] pe_a;
        logic [31:0] pe_b;
    } frame_t;

    typedef struct {
        int done_cyc;
        int c[16];
    } result_t;

    logic [31:0] amem [1024];
    logic [31:0] bmem [1024];
    frame_t      exp_frames [int];
    result_t     exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    // Operand buffers with one cycle of read latency.
    initial begin
        a_rdata = '0;
        b_rdata = '0;
    end
    always @(posedge clk) begin
        if (a_en) a_rdata <= amem[a_addr];
        if (b_en) b_rdata <= bmem[b_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array: operands hop one PE per cycle.
    byte ar [4][4];
    byte br [4][4];
    int  acc [4][4];
    byte pa [4];
    byte pb [4];
    assign pa[0] = pe_a0; assign pa[1] = pe_a1; assign pa[2] = pe_a2; assign pa[3] = pe_a3;
    assign pb[0] = pe_b0; assign pb[1] = pe_b1; assign pb[2] = pe_b2; assign pb[3] = pe_b3;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (rst || pe_clear) begin
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                    acc[i][j] <= 0;
                end else begin
                    ar[i][j]  <= (j == 0) ? pa[i] : ar[i][j-1];
                    br[i][j]  <= (i == 0) ? pb[j] : br[i-1][j];
                    acc[i][j] <= acc[i][j] + int'(ar[i][j]) * int'(br[i][j]);
                end
            end
        end
    end

    function automatic byte lane(input logic [31:0] w, input int i);
        return w[i*8 +: 8];
    endfunction

    function automatic frame_t get_frame(input int c);
        if (exp_frames.exists(c)) return exp_frames[c];
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    // Build the expected frames of one tile accepted in cycle s and queue its result.
    task automatic schedule_run(input int s, input int k, input logic [9:0] ab, input logic [9:0] bb,
                                input bit use_hand, input int hand [16]);
        frame_t      f;
        result_t     r;
        logic [9:0]  aa, ba;
        for (int c = s + 1; c <= s + k + 11; c++) begin
            f = get_frame(c); f.busy = 1'b1; exp_frames[c] = f;
        end
        f = get_frame(s + 1);      f.pe_clear = 1'b1; exp_frames[s + 1] = f;
        f = get_frame(s + k + 11); f.done = 1'b1;     exp_frames[s + k + 11] = f;
        for (int idx = 0; idx < k; idx++) begin
            aa = ab + 10'(idx);
            ba = bb + 10'(idx);
            f = get_frame(s + 2 + idx);
            f.a_en = 1'b1; f.b_en = 1'b1; f.a_addr = aa; f.b_addr = ba;
            exp_frames[s + 2 + idx] = f;
            for (int i = 0; i < 4; i++) begin
                f = get_frame(s + 4 + idx + i);
                f.pe_a[i*8 +: 8] = amem[aa][i*8 +: 8];
                f.pe_b[i*8 +: 8] = bmem[ba][i*8 +: 8];
                exp_frames[s + 4 + idx + i] = f;
            end
        end
        r.done_cyc = s + k + 11;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r.c[i*4 + j] = 0;
                for (int kk = 0; kk < k; kk++) begin
                    aa = ab + 10'(kk);
                    ba = bb + 10'(kk);
                    r.c[i*4 + j] += int'(lane(amem[aa], i)) * int'(lane(bmem[ba], j));
                end
            end
        end
        if (use_hand) r.c = hand;
        exp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse this cycle; returns the acceptance cycle.
    task automatic applyStimulus(input int k, input logic [9:0] ab, input logic [9:0] bb,
                                 input bit use_hand, input int hand [16], output int s);
        step();
        start  = 1'b1;
        k_len  = KLEN_W'(k);
        a_base = ab;
        b_base = bb;
        s      = cyc;
        schedule_run(s, k, ab, bb, use_hand, hand);
        step();
        start  = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs to the expected frame; pop results on done.
    always @(negedge clk) begin
        frame_t  e, a;
        result_t r;
        if (mon_en) begin
            e = get_frame(cyc);
            a = {busy, done, pe_clear, a_en, b_en, a_addr, b_addr,
                 {pe_a3, pe_a2, pe_a1, pe_a0}, {pe_b3, pe_b2, pe_b1, pe_b0}};
            checkOutput("frame", 128'(a), 128'(e));
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkValue("unexpected_done", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    checkValue("done_cycle", cyc, r.done_cyc);
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            checkValue($sformatf("acc[%0d][%0d]", i, j), acc[i][j], r.c[i*4 + j]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int s;
        int none [16];
        int h_rows [16];
        int h_ext [16];
        int h_zero [16];
        int del_keys [$];

        for (int n = 0; n < 16; n++) begin
            none[n]   = 0;
            h_rows[n] = (n / 4) + 1;
            h_ext[n]  = -65024;
            h_zero[n] = 0;
        end
        for (int n = 0; n < 1024; n++) begin
            amem[n] = '0;
            bmem[n] = '0;
        end
        amem[0]     = 32'h04030201;  bmem[0]     = 32'h01010101;
        amem[10'h3FE] = 32'h7F02FD10; bmem[10'h100] = 32'h01FF0302;
        amem[10'h3FF] = 32'h80050601; bmem[10'h101] = 32'hFE04807F;
        amem[10'h000 + 10'h0] = 32'h04030201;
        amem[10'h001] = 32'h03F9EC22; bmem[10'h102] = 32'h0A0B0C0D;
        bmem[10'h103] = 32'hF0E0D0C0;
        for (int n = 0; n < 4; n++) begin
            amem[10'h200 + n] = 32'h80808080;
            bmem[10'h200 + n] = 32'h7F7F7F7F;
            amem[10'h050 + n] = 32'h01020304 + 32'(n);
            bmem[10'h060 + n] = 32'hFF01FE02 ^ 32'(n << 3);
        end

        rst = 1'b1; start = 1'b0; k_len = '0; a_base = '0; b_base = '0;
        step(); step(); step();
        rst = 1'b0;
        mon_en = 1'b1;
        $display("[TB] reset released");

        repeat (4) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        $display("[TB] K=1 unit operands");
        applyStimulus(1, 10'h000, 10'h000, 1'b1, h_rows, s);
        repeat (1 + 13) step();

        $display("[TB] K=4 wrapping A address");
        applyStimulus(4, 10'h3FE, 10'h100, 1'b0, none, s);
        repeat (4 + 13) step();

        $display("[TB] K=4 signed extremes");
        applyStimulus(4, 10'h200, 10'h200, 1'b1, h_ext, s);
        repeat (4 + 13) step();

        $display("[TB] K=0");
        applyStimulus(0, 10'h123, 10'h321, 1'b1, h_zero, s);
        repeat (0 + 13) step();

        $display("[TB] start during FEED and DONE ignored");
        applyStimulus(6, 10'h050, 10'h060, 1'b0, none, s);
        repeat (3) step();
        start = 1'b1; k_len = 11'd2; a_base = 10'h3FF; b_base = 10'h3FF;
        step();
        start = 1'b0;
        while (cyc < s + 6 + 11) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();

        $display("[TB] start held high: back-to-back runs");
        step();
        start = 1'b1; k_len = 11'd2; a_base = 10'h050; b_base = 10'h060;
        s = cyc;
        schedule_run(s, 2, 10'h050, 10'h060, 1'b0, none);
        schedule_run(s + 2 + 12, 2, 10'h050, 10'h060, 1'b0, none);
        while (cyc < s + 2 + 13) step();
        start = 1'b0;
        repeat (2 + 13) step();

        $display("[TB] reset during FEED");
        applyStimulus(8, 10'h050, 10'h060, 1'b0, none, s);
        while (cyc < s + 6) step();
        rst = 1'b1;
        foreach (exp_frames[key]) if (key > s + 6) del_keys.push_back(key);
        foreach (del_keys[n]) exp_frames.delete(del_keys[n]);
        void'(exp_q.pop_back());
        step();
        rst = 1'b0;
        repeat (25) step();

        checkValue("pending_done_results", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
